// File: rtl/fullconn_pkg.sv
// Shared definitions for the layer-1 fully connected training update block.
//   - state_t      : training sequencer states
//   - *_D          : default sizing constants used as top-level parameter defaults
//   - entry_idx()  : flat weight/counter index of (node, input); input N_IN is the bias
//   - sat_sym()    : symmetric clamp to +/-(2^(w_bits-1)-1); the most negative
//                    code is never produced, so |W| always fits in w_bits-1 bits
package fullconn_pkg;

  localparam int N_IN_D     = 5;
  localparam int N_NODE_D   = 25;
  localparam int WIN_LOG_D  = 8;
  localparam int W_BITS_D   = 16;
  localparam int LR_SHIFT_D = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    APPLY = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int entry_idx(input int node, input int inp, input int n_in);
    return node * (n_in + 1) + inp;
  endfunction

  function automatic int sat_sym(input int v, input int w_bits);
    int lim;
    lim = (1 << (w_bits - 1)) - 1;
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/fullconn_grad_counter.sv
// Signed up/down gradient counter for one weight or bias entry.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset (clears the count)
//   i_clr  : synchronous clear, wins over counting
//   i_en   : count this cycle (gated gradient bit)
//   i_dn   : direction, 1 = decrement (negative error sign)
//   o_cnt  : current signed count
// The window length bounds |count| to 2^WIN_LOG, so the width of WIN_LOG+2
// cannot overflow and no saturation is needed.
module fullconn_grad_counter
  import fullconn_pkg::*;
#(
  parameter int CW = WIN_LOG_D + 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_dn,
  output logic signed [CW-1:0] o_cnt
);

  localparam logic signed [CW-1:0] ONE = CW'(1);

  logic signed [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= i_dn ? (r_cnt - ONE) : (r_cnt + ONE);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fullconn_update_l1.sv
// Layer-1 fully connected training update.
// Integrates gated, signed gradient bits over a 2^WIN_LOG cycle window, then
// applies a shifted saturating descent step to one node per cycle.
// Ports:
//   CLK, INIT          : clock, asynchronous active-high reset
//   start              : begin a training window (taken only in IDLE)
//   a_input, zp, err   : forward input, derivative and error magnitude streams
//   SIGN_err           : error sign per node (1 = negative)
//   ld_en/addr/data    : weight load port, honoured only in IDLE
//   busy, done         : window/apply in progress, one-cycle completion pulse
//   W_MAG, W_SIGN      : sign-magnitude view of every stored weight
//
// state | meaning
// IDLE  | waiting for start; loads accepted
// ACCUM | sampling gradient streams for 2^WIN_LOG cycles
// APPLY | updating node r_node's weights and bias, one node per cycle
// DONE  | completion pulse, returns to IDLE
module fullconn_update_l1
  import fullconn_pkg::*;
#(
  parameter int N_IN     = N_IN_D,
  parameter int N_NODE   = N_NODE_D,
  parameter int WIN_LOG  = WIN_LOG_D,
  parameter int W_BITS   = W_BITS_D,
  parameter int LR_SHIFT = LR_SHIFT_D
) (
  input  logic                                      CLK,
  input  logic                                      INIT,
  input  logic                                      start,
  input  logic [N_IN-1:0]                           a_input,
  input  logic [N_NODE-1:0]                         zp,
  input  logic [N_NODE-1:0]                         err,
  input  logic [N_NODE-1:0]                         SIGN_err,
  input  logic                                      ld_en,
  input  logic [7:0]                                ld_addr,
  input  logic [W_BITS-1:0]                         ld_data,
  output logic                                      busy,
  output logic                                      done,
  output logic [N_NODE*(N_IN+1)*(W_BITS-1)-1:0]     W_MAG,
  output logic [N_NODE*(N_IN+1)-1:0]                W_SIGN
);

  localparam int N_ENT  = N_NODE * (N_IN + 1);
  localparam int CW     = WIN_LOG + 2;
  localparam int NODE_W = $clog2(N_NODE);

  state_t                   r_state;
  logic [WIN_LOG-1:0]       r_win;
  logic [NODE_W-1:0]        r_node;
  logic                     r_busy;
  logic                     r_done;
  logic signed [W_BITS-1:0] r_w [N_ENT];

  logic signed [CW-1:0]     w_cnt   [N_ENT];
  logic signed [W_BITS-1:0] w_w_new [N_IN+1];
  logic                     w_accum;
  logic                     w_apply;

  assign w_accum = (r_state == ACCUM);
  assign w_apply = (r_state == APPLY);

  for (genvar j = 0; j < N_NODE; j++) begin : g_node
    for (genvar i = 0; i <= N_IN; i++) begin : g_ent
      logic w_g;
      if (i < N_IN) begin : g_wt
        assign w_g = err[j] & zp[j] & a_input[i];
      end else begin : g_bias
        assign w_g = err[j] & zp[j];
      end

      // A node's counters are cleared on the same edge its weights absorb them.
      fullconn_grad_counter #(.CW(CW)) u_cnt (
        .i_clk (CLK),
        .i_rst (INIT),
        .i_clr (w_apply && (r_node == NODE_W'(j))),
        .i_en  (w_accum & w_g),
        .i_dn  (SIGN_err[j]),
        .o_cnt (w_cnt[j*(N_IN+1)+i])
      );
    end
  end

  // Only one node updates per cycle, so a single row of N_IN+1 saturating
  // subtractors is shared through a node-select mux. The arithmetic shift of
  // the signed count gives floor(C / 2^LR_SHIFT).
  always_comb begin
    for (int i = 0; i <= N_IN; i++) begin
      w_w_new[i] = W_BITS'(sat_sym(
                     int'(r_w[entry_idx(int'(r_node), i, N_IN)]) -
                     (int'(w_cnt[entry_idx(int'(r_node), i, N_IN)]) >>> LR_SHIFT),
                     W_BITS));
    end
  end

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_node  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int e = 0; e < N_ENT; e++)
        r_w[e] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_en && (int'(ld_addr) < N_ENT))
            r_w[ld_addr] <= W_BITS'(sat_sym(int'($signed(ld_data)), W_BITS));
          if (start) begin
            r_state <= ACCUM;
            r_win   <= '1;
            r_busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (r_win == '0) begin
            r_state <= APPLY;
            r_node  <= '0;
          end else begin
            r_win <= r_win - WIN_LOG'(1);
          end
        end
        APPLY: begin
          for (int i = 0; i <= N_IN; i++)
            r_w[entry_idx(int'(r_node), i, N_IN)] <= w_w_new[i];
          if (r_node == NODE_W'(N_NODE - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_node <= r_node + NODE_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  for (genvar e = 0; e < N_ENT; e++) begin : g_out
    assign W_SIGN[e] = r_w[e][W_BITS-1];
    assign W_MAG[e*(W_BITS-1) +: (W_BITS-1)] =
      (W_BITS-1)'(r_w[e][W_BITS-1] ? -r_w[e] : r_w[e]);
  end

endmodule

// File: tb/tb_fullconn_update_l1.sv
module tb_fullconn_update_l1;

  localparam int N_IN   = 5;
  localparam int N_NODE = 25;
  localparam int WIN    = 256;
  localparam int N_ENT  = N_NODE * (N_IN + 1);
  localparam int MB     = 15;
  localparam int LIM    = 32767;

  logic                  CLK = 1'b0;
  logic                  INIT;
  logic                  start;
  logic [N_IN-1:0]       a_input;
  logic [N_NODE-1:0]     zp, err, SIGN_err;
  logic                  ld_en;
  logic [7:0]            ld_addr;
  logic [15:0]           ld_data;
  logic                  busy, done;
  logic [N_ENT*MB-1:0]   W_MAG;
  logic [N_ENT-1:0]      W_SIGN;

  fullconn_update_l1 dut (
    .CLK      (CLK),
    .INIT     (INIT),
    .start    (start),
    .a_input  (a_input),
    .zp       (zp),
    .err      (err),
    .SIGN_err (SIGN_err),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .busy     (busy),
    .done     (done),
    .W_MAG    (W_MAG),
    .W_SIGN   (W_SIGN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: weights and per-window signed gradient counts.
  int m_w [N_ENT];
  int m_c [N_ENT];
  // Scoreboard: per window, the edge done must be seen on, then N_ENT weights.
  int q_exp [$];

  function automatic int clamp(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  // floor(c / 16) for the learning-rate step
  function automatic int floor16(input int c);
    if (c >= 0) return c / 16;
    return -((-c + 15) / 16);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wmag_any"}, int'(|W_MAG), 0);
    check({tag, "_wsign_any"}, int'(|W_SIGN), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: every done pulse must match the oldest expected window result.
  int mon_dc, mon_w, mon_act, mon_exp;
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (q_exp.size() < N_ENT + 1) begin
        check("done_unexpected", int'(done), 0);
      end else begin
        mon_dc = q_exp.pop_front();
        check("done_edge", cyc + 1, mon_dc);
        check("busy_at_done", int'(busy), 0);
        for (int e = 0; e < N_ENT; e++) begin
          mon_w   = q_exp.pop_front();
          mon_exp = ((mon_w < 0) ? 65536 : 0) + ((mon_w < 0) ? -mon_w : mon_w);
          mon_act = (W_SIGN[e] ? 65536 : 0) + int'(W_MAG[e*MB +: MB]);
          check($sformatf("w_entry%0d(sign*65536+mag)", e), mon_act, mon_exp);
        end
      end
    end
  end

  task automatic clear_streams();
    a_input = '0; zp = '0; err = '0; SIGN_err = '0;
    start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic do_load(input int addr, input int data);
    @(negedge CLK);
    ld_en = 1'b1; ld_addr = 8'(addr); ld_data = 16'(data);
    if (addr < N_ENT) m_w[addr] = clamp(data);
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  task automatic pulse_init();
    @(negedge CLK);
    INIT = 1'b1;
    @(negedge CLK);
    INIT = 1'b0;
    for (int e = 0; e < N_ENT; e++) m_w[e] = 0;
    q_exp.delete();
  endtask

  // mode 0: all streams 1, positive error   1: all 1, negative error
  //      2: as 1 but node 3 derivative 0    3: random streams
  //      4: random streams plus start/ld_en injected during ACCUM
  // abort_at > 0 asserts INIT before that sample edge. ld_a >= 0 loads
  // alongside start.
  task automatic run_window(input int mode, input int abort_at, input int ld_a, input int ld_d);
    int t0;
    logic ai, g;
    for (int e = 0; e < N_ENT; e++) m_c[e] = 0;
    @(negedge CLK);
    start = 1'b1;
    if (ld_a >= 0) begin
      ld_en = 1'b1; ld_addr = 8'(ld_a); ld_data = 16'(ld_d);
      if (ld_a < N_ENT) m_w[ld_a] = clamp(ld_d);
    end
    @(posedge CLK);
    @(negedge CLK);
    t0 = cyc;
    start = 1'b0; ld_en = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int n = 1; n <= WIN; n++) begin
      if (n > 1) @(negedge CLK);
      if (n == abort_at) begin
        INIT = 1'b1;
        clear_streams();
        for (int e = 0; e < N_ENT; e++) m_w[e] = 0;
        @(negedge CLK);
        check_reset_outputs("init_mid");
        INIT = 1'b0;
        return;
      end
      case (mode)
        0: begin a_input = '1; zp = '1; err = '1; SIGN_err = '0; end
        1: begin a_input = '1; zp = '1; err = '1; SIGN_err = '1; end
        2: begin a_input = '1; zp = '1; zp[3] = 1'b0; err = '1; SIGN_err = '1; end
        default: begin
          a_input  = 5'($urandom) | 5'($urandom);
          zp       = 25'($urandom) | 25'($urandom);
          err      = 25'($urandom) | 25'($urandom);
          SIGN_err = 25'($urandom);
        end
      endcase
      if (mode == 4) begin
        start = 1'($urandom);
        ld_en = 1'b1;
        ld_addr = 8'($urandom_range(0, N_ENT - 1));
        ld_data = 16'($urandom);
      end
      for (int j = 0; j < N_NODE; j++) begin
        for (int i = 0; i <= N_IN; i++) begin
          if (i < N_IN) ai = a_input[i]; else ai = 1'b1;
          g = err[j] & zp[j] & ai;
          if (g) m_c[j*(N_IN+1)+i] += SIGN_err[j] ? -1 : 1;
        end
      end
    end
    @(negedge CLK);
    clear_streams();
    q_exp.push_back(t0 + WIN + N_NODE + 1);
    for (int e = 0; e < N_ENT; e++) begin
      m_w[e] = clamp(m_w[e] - floor16(m_c[e]));
      q_exp.push_back(m_w[e]);
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && q_exp.size() > 0; k++) @(negedge CLK);
    if (q_exp.size() != 0) begin
      check("done_timeout_pending", q_exp.size(), 0);
      q_exp.delete();
    end
    @(negedge CLK);
  endtask

  initial begin
    INIT = 1'b1;
    clear_streams();
    for (int e = 0; e < N_ENT; e++) begin m_w[e] = 0; m_c[e] = 0; end
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    INIT = 1'b0;
    repeat (20) @(negedge CLK);
    check_reset_outputs("idle");

    // every counter reaches +256, step 16: all weights -16
    run_window(0, -1, -1, 0);
    wait_done();

    // negative error from zero, with a load issued alongside start
    pulse_init();
    run_window(1, -1, 0, 100);
    wait_done();

    // positive saturation on node 0 bias, node 3 frozen by zp
    do_load(5, 32760);
    run_window(2, -1, -1, 0);
    wait_done();

    // negative saturation, most-negative load clamp, out-of-range load ignored
    do_load(7, -32760);
    do_load(8, -32768);
    do_load(149, 32767);
    do_load(200, 1234);
    run_window(0, -1, -1, 0);
    wait_done();

    // start and ld_en during ACCUM are ignored, window length unchanged
    run_window(4, -1, -1, 0);
    wait_done();

    // INIT mid-window discards everything; a fresh window completes
    run_window(3, 100, -1, 0);
    repeat (5) @(negedge CLK);
    run_window(3, -1, -1, 0);
    wait_done();

    // random windows over randomly preloaded weights
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 6; k++)
        do_load($urandom_range(0, N_ENT - 1), $urandom_range(0, 60000) - 30000);
      run_window(3, -1, 0 + $urandom_range(0, N_ENT - 1), $urandom_range(0, 2000) - 1000);
      wait_done();
    end

    repeat (10) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
